// File: rtl/lab4_pll_pkg.sv
// -----------------------------------------------------------------------------
// lab4_pll_pkg
// Shared types and constants for the PLL reset/lock sequencer.
//   pll_ctrl_state_t : 3-bit sequencer state, encodings visible on state_o
//   pll_ctrl_outs_t  : per-state output set {pll_rst, domain_rst_n, fault}
//   state_outputs()  : maps a state to its fixed output set
//   max3()           : sizing helper for the shared cycle counter
// -----------------------------------------------------------------------------
package lab4_pll_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_ctrl_state_t;

    typedef struct packed {
        logic pll_rst;
        logic domain_rst_n;
        logic fault;
    } pll_ctrl_outs_t;

    localparam int unsigned DEF_RST_CYCLES          = 32'd16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 32'd1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 32'd65536;
    localparam int unsigned DEF_MAX_RETRIES         = 32'd3;

    localparam logic [7:0]  LOSS_CNT_MAX            = 8'd255;

    // Fixed output set of each state. Unused encodings keep the PLL and the
    // downstream domain in reset without claiming a fault.
    function automatic pll_ctrl_outs_t state_outputs(input pll_ctrl_state_t st);
        pll_ctrl_outs_t o;
        case (st)
            ST_RESET_PLL: o = '{pll_rst: 1'b1, domain_rst_n: 1'b0, fault: 1'b0};
            ST_WAIT_LOCK: o = '{pll_rst: 1'b0, domain_rst_n: 1'b0, fault: 1'b0};
            ST_STABILIZE: o = '{pll_rst: 1'b0, domain_rst_n: 1'b0, fault: 1'b0};
            ST_RUN:       o = '{pll_rst: 1'b0, domain_rst_n: 1'b1, fault: 1'b0};
            ST_FAULT:     o = '{pll_rst: 1'b1, domain_rst_n: 1'b0, fault: 1'b1};
            default:      o = '{pll_rst: 1'b1, domain_rst_n: 1'b0, fault: 1'b0};
        endcase
        return o;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/lab4_pll_reset_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// lab4_sync2
// Generic two-flop single-bit synchronizer with asynchronous active-low reset.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (both flops clear to 0)
//   i_d     : asynchronous input bit
//   o_q     : synchronized output (two destination-clock edges of latency)
// -----------------------------------------------------------------------------
module lab4_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; r_meta may go metastable and is never used elsewhere.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lab4_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// lab4_pll_reset_ctrl
// Reset and lock sequencer for the 50 MHz -> 65 MHz pixel-clock PLL. Runs in
// the reference-clock domain, pulses the PLL reset, qualifies the lock signal,
// and releases the reset of the outclk_0 domain once lock has been stable.
// Ports:
//   clk            : 50 MHz reference clock (same net as PLL refclk)
//   reset_n        : asynchronous active-low reset
//   pll_locked     : PLL locked, asynchronous to clk
//   soft_reset_req : single-cycle request to restart the sequence
//   pll_rst        : PLL reset, active high (registered)
//   domain_rst_n   : active-low reset for the outclk_0 domain (registered)
//   fault          : retries exhausted (registered)
//   state_o        : current state encoding (registered)
//   lock_loss_cnt  : saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module lab4_pll_reset_ctrl
    import lab4_pll_pkg::*;
#(
    parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       domain_rst_n,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned CNT_W =
        $clog2(max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

    // Terminal counts: a state that lasts N cycles exits when the counter
    // reads N-1, the counter having been cleared on entry.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    logic            w_locked_s;
    pll_ctrl_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]      r_retry_cnt;

    pll_ctrl_state_t w_next_state;
    pll_ctrl_outs_t  w_next_outs;
    logic            w_cnt_clr;
    logic            w_cnt_en;
    logic            w_retry_inc;
    logic            w_retry_clr;
    logic            w_loss_inc;

    lab4_sync2 u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    // Next-state and counter-control decode; the soft reset request wins
    // over every state-specific transition.
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_retry_inc  = 1'b0;
        w_retry_clr  = 1'b0;
        w_loss_inc   = 1'b0;

        if (soft_reset_req) begin
            w_next_state = ST_RESET_PLL;
            w_cnt_clr    = 1'b1;
            w_retry_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_en     = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_next_state = ST_STABILIZE;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_retry_inc  = 1'b1;
                        w_cnt_clr    = 1'b1;
                        // Compare against the post-increment retry count.
                        if ((r_retry_cnt + 4'd1) == RETRY_LIMIT) begin
                            w_next_state = ST_FAULT;
                        end else begin
                            w_next_state = ST_RESET_PLL;
                        end
                    end else begin
                        w_cnt_en     = 1'b1;
                    end
                end
                ST_STABILIZE: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_WAIT_LOCK;
                        w_cnt_clr    = 1'b1;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_next_state = ST_RUN;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_en     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_next_state = ST_RESET_PLL;
                        w_cnt_clr    = 1'b1;
                        w_retry_clr  = 1'b1;
                        w_loss_inc   = 1'b1;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    w_next_state = ST_FAULT;
                end
                default: begin
                    // Illegal encoding: restart cleanly.
                    w_next_state = ST_RESET_PLL;
                    w_cnt_clr    = 1'b1;
                    w_retry_clr  = 1'b1;
                end
            endcase
        end

        w_next_outs = state_outputs(w_next_state);
    end

    // Sequencer state, shared counter, retry/loss counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_RESET_PLL;
            r_cnt         <= {CNT_W{1'b0}};
            r_retry_cnt   <= 4'd0;
            lock_loss_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            domain_rst_n  <= 1'b0;
            fault         <= 1'b0;
            state_o       <= 3'd0;
        end else begin
            r_state <= w_next_state;

            // Counter only runs while a timed state holds; RUN/FAULT keep it at 0.
            if (w_cnt_clr) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_cnt_en) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= {CNT_W{1'b0}};
            end

            if (w_retry_clr) begin
                r_retry_cnt <= 4'd0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 4'd1;
            end else begin
                r_retry_cnt <= r_retry_cnt;
            end

            if (w_loss_inc && (lock_loss_cnt != LOSS_CNT_MAX)) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end else begin
                lock_loss_cnt <= lock_loss_cnt;
            end

            pll_rst      <= w_next_outs.pll_rst;
            domain_rst_n <= w_next_outs.domain_rst_n;
            fault        <= w_next_outs.fault;
            state_o      <= w_next_state;
        end
    end

endmodule

// File: tb/tb_lab4_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lab4_pll_reset_ctrl
// Directed bench for lab4_pll_reset_ctrl with RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
// Cycle n means "just after the n-th rising edge following reset release".
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_lab4_pll_reset_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst;
    logic       domain_rst_n;
    logic       fault;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lab4_pll_reset_ctrl #(
        .RST_CYCLES          (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .domain_rst_n   (domain_rst_n),
        .fault          (fault),
        .state_o        (state_o),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    typedef struct {
        string      name;
        bit         do_rst;
        logic       locked;
        logic       srst;
        int         adv;
        logic       exp_prst;
        logic       exp_drn;
        logic       exp_flt;
        logic [2:0] exp_st;
        logic [7:0] exp_llc;
    } vec_t;

    vec_t vq[$];

    function automatic logic [13:0] pack(input logic prst, input logic drn,
                                         input logic flt, input logic [2:0] st,
                                         input logic [7:0] llc);
        return {prst, drn, flt, st, llc};
    endfunction

    function automatic logic [13:0] outs_now();
        return {pll_rst, domain_rst_n, fault, state_o, lock_loss_cnt};
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = outs_now();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {prst,drn,flt,st,llc}=%b_%b_%b_%0d_%0d, expected %b_%b_%b_%0d_%0d",
                     name, act[13], act[12], act[11], act[10:8], act[7:0],
                     exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        soft_reset_req = 1'b0;
        tick(3);
        check("rst_hold", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'd0));
        reset_n = 1'b1;
    endtask

    function automatic void add(input string nm, input bit r, input logic lk,
                                input logic sr, input int adv, input logic prst,
                                input logic drn, input logic flt,
                                input logic [2:0] st, input logic [7:0] llc);
        vec_t v;
        v.name = nm; v.do_rst = r; v.locked = lk; v.srst = sr; v.adv = adv;
        v.exp_prst = prst; v.exp_drn = drn; v.exp_flt = flt;
        v.exp_st = st; v.exp_llc = llc;
        vq.push_back(v);
    endfunction

    int llc_exp;

    initial begin
        // name, reset, locked, srst, advance, pll_rst, drn, fault, state, llc
        // Nominal lock: lock raised at cycle 10.
        add("s1_c0",    1, 1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s1_c3",    0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s1_c4",    0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s1_c10",   0, 1'b0, 1'b0, 6,  1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s1_c12",   0, 1'b1, 1'b0, 2,  1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s1_c13",   0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        add("s1_c20",   0, 1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        add("s1_c21",   0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 3'd3, 8'd0);
        add("s1_c30",   0, 1'b1, 1'b0, 9,  1'b0, 1'b1, 1'b0, 3'd3, 8'd0);
        // Timeout retries: no lock at all.
        add("s2_c0",    1, 1'b0, 1'b0, 0,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s2_c4",    0, 1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s2_c35",   0, 1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s2_c36",   0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s2_c39",   0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s2_c40",   0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s2_c71",   0, 1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s2_c72",   0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 3'd4, 8'd0);
        add("s2_c92",   0, 1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b1, 3'd4, 8'd0);
        // Recover from FAULT with a soft reset, then lock.
        add("s3_c93",   0, 1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s3_c96",   0, 1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        add("s3_c97",   0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        add("s3_c98",   0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        add("s3_c105",  0, 1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        add("s3_c106",  0, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 3'd3, 8'd0);

        // Initial power-on reset window.
        reset_n = 1'b0;
        tick(2);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].do_rst) begin
                do_reset();
            end
            pll_locked     = vq[i].locked;
            soft_reset_req = vq[i].srst;
            if (vq[i].adv > 0) begin
                tick(1);
                soft_reset_req = 1'b0;
                if (vq[i].adv > 1) begin
                    tick(vq[i].adv - 1);
                end
            end
            check(vq[i].name, pack(vq[i].exp_prst, vq[i].exp_drn, vq[i].exp_flt,
                                   vq[i].exp_st, vq[i].exp_llc));
        end

        // Soft reset in the same cycle RUN would see the lock drop.
        do_reset();
        pll_locked = 1'b1;
        tick(13);
        check("s6_run", pack(1'b0, 1'b1, 1'b0, 3'd3, 8'd0));
        pll_locked = 1'b0;
        tick(2);
        check("s6_pre_srst", pack(1'b0, 1'b1, 1'b0, 3'd3, 8'd0));
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
        check("s6_srst_drop", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'd0));
        tick(1);
        check("s6_srst_hold", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'd0));

        // Lock glitch at STABILIZE cycle 5 (STABILIZE entered at cycle 5).
        do_reset();
        pll_locked = 1'b1;
        tick(5);
        check("s4_stab_entry", pack(1'b0, 1'b0, 1'b0, 3'd2, 8'd0));
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        check("s4_c12", pack(1'b0, 1'b0, 1'b0, 3'd2, 8'd0));
        pll_locked = 1'b1;
        tick(1);
        check("s4_back_wait", pack(1'b0, 1'b0, 1'b0, 3'd1, 8'd0));
        tick(1);
        check("s4_c14", pack(1'b0, 1'b0, 1'b0, 3'd1, 8'd0));
        tick(1);
        check("s4_restab", pack(1'b0, 1'b0, 1'b0, 3'd2, 8'd0));
        tick(7);
        check("s4_c22", pack(1'b0, 1'b0, 1'b0, 3'd2, 8'd0));
        tick(1);
        check("s4_run", pack(1'b0, 1'b1, 1'b0, 3'd3, 8'd0));

        // 300 lock losses in RUN; counter saturates at 255.
        llc_exp = 0;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick(2);
            check("s5_pre", pack(1'b0, 1'b1, 1'b0, 3'd3, 8'(llc_exp)));
            tick(1);
            if (llc_exp < 255) begin
                llc_exp = llc_exp + 1;
            end
            check("s5_drop", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'(llc_exp)));
            pll_locked = 1'b1;
            tick(13);
            check("s5_rerun", pack(1'b0, 1'b1, 1'b0, 3'd3, 8'(llc_exp)));
        end

        // Asynchronous reset in the middle of STABILIZE.
        pll_locked = 1'b0;
        tick(3);
        check("s6_loss_sat", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'd255));
        pll_locked = 1'b1;
        tick(7);
        check("s6_stab", pack(1'b0, 1'b0, 1'b0, 3'd2, 8'd255));
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_async_rst", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'd0));
        tick(2);
        check("s6_rst_held", pack(1'b1, 1'b0, 1'b0, 3'd0, 8'd0));
        reset_n = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lab4_pll_reset_ctrl.md
# lab4_pll_reset_ctrl

Reset and lock sequencer for the system PLL that derives the 65 MHz pixel clock from the 50 MHz board reference. It runs in the 50 MHz reference domain and drives the PLL `rst` input. It qualifies the asynchronous `locked` output, then releases a reset for logic clocked by `outclk_0`. Lock timeouts trigger bounded retries, and lock loss during operation is counted and recovered automatically.

## Interface

**Parameters**
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles of synchronized lock required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before the attempt fails (≥2).
- `MAX_RETRIES`, 3: failed attempts tolerated before entering FAULT (1–15).

**Ports**
- `clk` in 1: 50 MHz reference clock, the same net as the PLL `refclk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`; asynchronous to `clk`.
- `soft_reset_req` in 1: single-cycle pulse that restarts the sequence.
- `pll_rst` out 1: drives PLL `rst`; active high.
- `domain_rst_n` out 1: active-low reset for the `outclk_0` domain.
- `fault` out 1: retries exhausted.
- `state_o` out 3: current state encoding.
- `lock_loss_cnt` out 8: count of lock losses seen in RUN; saturates at 255.

## Operation

- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. All decisions use `locked_s`.
- Each state has an encoding and a fixed output set:
  - RESET_PLL = 0: `pll_rst`=1, `domain_rst_n`=0.
  - WAIT_LOCK = 1: `pll_rst`=0, `domain_rst_n`=0.
  - STABILIZE = 2: `pll_rst`=0, `domain_rst_n`=0.
  - RUN = 3: `pll_rst`=0, `domain_rst_n`=1.
  - FAULT = 4: `pll_rst`=1, `domain_rst_n`=0, `fault`=1.
- Transitions:
  - RESET_PLL: after `RST_CYCLES` cycles, go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK, lock seen: if `locked_s`=1, go to STABILIZE and clear the counter.
  - WAIT_LOCK, timeout: when the counter reaches `LOCK_TIMEOUT_CYCLES`-1 without lock, increment `retry_cnt`. If the new value equals `MAX_RETRIES`, go to FAULT; otherwise go to RESET_PLL.
  - STABILIZE, lock dropped: if `locked_s`=0, return to WAIT_LOCK. Clear the counter; the timeout restarts.
  - STABILIZE, lock stable: after `LOCK_STABLE_CYCLES` consecutive cycles of `locked_s`=1, go to RUN.
  - RUN: if `locked_s`=0, increment `lock_loss_cnt` (saturating), clear `retry_cnt`, and go to RESET_PLL.
  - FAULT: held until `soft_reset_req`.
- `soft_reset_req` in any state goes to RESET_PLL, clears `retry_cnt` and the counter, and has priority over every other transition. `lock_loss_cnt` is not cleared and is not incremented, even if lock drops in the same cycle.
- One shared cycle counter serves all states. Its width is `$clog2` of the maximum of the three cycle parameters, plus 1. It never wraps; each state clears it on exit.
- `retry_cnt` is 4 bits and is internal.

## Timing

- Reset values (asynchronous on `reset_n` low):
  - state = RESET_PLL
  - `pll_rst`=1
  - `domain_rst_n`=0
  - `fault`=0
  - `state_o`=0
  - `lock_loss_cnt`=0
  - counters = 0
  - synchronizer flops = 0
- All outputs are registered, with no combinational path from any input.
- `pll_rst` stays high while `reset_n` is low and for exactly `RST_CYCLES` rising edges after release.
- `pll_locked` rise to the STABILIZE entry takes 3 cycles: 2 for the synchronizer and 1 for the state register.
- `domain_rst_n` rises exactly `LOCK_STABLE_CYCLES` cycles after the STABILIZE entry.
- Lock drop in RUN to `domain_rst_n`=0 takes 3 cycles.
- `domain_rst_n` asserts asynchronously in the consuming domain. The consumer re-synchronizes its deassertion to `outclk_0` with its own 2-flop reset synchronizer; that synchronizer is not part of this block.
- `reset_n` asserted mid-sequence aborts immediately to the reset values.

## Structure

- Shared package `lab4_pll_pkg` holds:
  - the `pll_ctrl_state_t` enum (3-bit, encodings as above);
  - default parameter constants.
- One sub-module, `lab4_sync2`: a generic 2-flop bit synchronizer with async active-low reset. It is reused for `pll_locked`.

## Test plan

All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.

1. **Nominal lock:** release `reset_n`, raise `pll_locked` at cycle 10 → `pll_rst` falls at cycle 4; `domain_rst_n` rises at cycle 21; `state_o` reads 3.
2. **Timeout retries:** hold `pll_locked`=0 → two 4-cycle `pll_rst` pulses, then `fault`=1 and `state_o`=4 at cycle 72; `pll_rst`=1 held.
3. **Recover from FAULT:** from scenario 2, pulse `soft_reset_req` and then raise `pll_locked` → `fault`=0 and the nominal sequence completes.
4. **Lock glitch during STABILIZE:** drop `pll_locked` for 2 cycles at STABILIZE cycle 5 → return to WAIT_LOCK; `domain_rst_n` stays 0 until 8 fresh stable cycles have elapsed.
5. **Lock loss in RUN:** drop `pll_locked` 300 times → `domain_rst_n`=0 three cycles after each drop; `lock_loss_cnt` ends at 255.
6. **Simultaneous events and async reset:** issue `soft_reset_req` in the same cycle as a lock drop in RUN → RESET_PLL and `lock_loss_cnt` unchanged. Assert `reset_n` mid-STABILIZE → all outputs return to reset values without waiting for a clock edge.
